// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - SHA-256 block compression controller built around one shared five-operand adder
// Every addition of a round and of the final chaining-value update goes through the single add5 instance.
module add5 (
  input  logic [31:0] op0,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] op3,
  input  logic [31:0] op4,
  output logic [31:0] sum
);
  assign sum = op0 + op1 + op2 + op3 + op4;
endmodule

module sha256_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] h_in,
  input  logic [31:0]  w_in,
  input  logic         w_valid,
  output logic         w_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] h_out
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {S_IDLE, S_RT1, S_RA, S_RE, S_FIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [31:0]      a, b, c, d, e, f, g, h;
  logic [31:0]      t1, a_new;
  logic [0:7][31:0] hv;
  logic [5:0]       t;
  logic [2:0]       i;
  logic [31:0]      op0, op1, op2, op3, op4, sum, var_i;
  logic [31:0]      big_s0, big_s1, ch, maj;

  assign big_s0 = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
  assign big_s1 = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
  assign ch     = (e & f) ^ (~e & g);
  assign maj    = (a & b) ^ (a & c) ^ (b & c);

  assign busy = (state == S_RT1) || (state == S_RA) || (state == S_RE) || (state == S_FIN);
  assign done = (state == S_DONE);

  add5 u_add5 (.op0(op0), .op1(op1), .op2(op2), .op3(op3), .op4(op4), .sum(sum));

  always_comb begin
    var_i = a;
    case (i)
      3'd0: var_i = a;
      3'd1: var_i = b;
      3'd2: var_i = c;
      3'd3: var_i = d;
      3'd4: var_i = e;
      3'd5: var_i = f;
      3'd6: var_i = g;
      3'd7: var_i = h;
      default: var_i = a;
    endcase
  end

  always_comb begin
    state_nx = state;
    w_ready  = 1'b0;
    op0 = '0;
    op1 = '0;
    op2 = '0;
    op3 = '0;
    op4 = '0;
    case (state)
      S_IDLE: if (start) state_nx = S_RT1;
      S_RT1: begin
        w_ready = 1'b1;
        op0 = h;
        op1 = big_s1;
        op2 = ch;
        op3 = K[t];
        op4 = w_in;
        if (w_valid) state_nx = S_RA;
      end
      S_RA: begin
        op0 = t1;
        op1 = big_s0;
        op2 = maj;
        state_nx = S_RE;
      end
      S_RE: begin
        op0 = d;
        op1 = t1;
        state_nx = (t == 6'd63) ? S_FIN : S_RT1;
      end
      S_FIN: begin
        op0 = hv[i];
        op1 = var_i;
        if (i == 3'd7) state_nx = S_DONE;
      end
      S_DONE: state_nx = start ? S_RT1 : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      {a, b, c, d, e, f, g, h} <= '0;
      t1    <= '0;
      a_new <= '0;
      hv    <= '0;
      t     <= '0;
      i     <= '0;
      h_out <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            {a, b, c, d, e, f, g, h} <= h_in;
            hv <= h_in;
            t  <= '0;
          end
        end
        S_RT1: if (w_valid) t1 <= sum;
        S_RA:  a_new <= sum;
        S_RE: begin
          h <= g;
          g <= f;
          f <= e;
          e <= sum;
          d <= c;
          c <= b;
          b <= a;
          a <= a_new;
          t <= t + 6'd1;
          if (t == 6'd63) i <= 3'd0;
        end
        S_FIN: begin
          hv[i] <= sum;
          i     <= i + 3'd1;
          // Last word bypasses the register so h_out is complete on DONE entry
          if (i == 3'd7) h_out <= {hv[0:6], sum};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb/tb_sha256_round_ctrl.sv - self-checking bench for sha256_round_ctrl
// Table-driven runs plus hand sequences for chaining, ignored start and mid-run reset.
module tb_sha256_round_ctrl;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_M1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2 = {480'h0, 32'h000001c0};

  logic         clk = 1'b0;
  logic         rst_n, start, w_valid, w_ready, busy, done;
  logic [255:0] h_in, h_out;
  logic [31:0]  w_in;

  sha256_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .h_in(h_in), .w_in(w_in),
    .w_valid(w_valid), .w_ready(w_ready), .busy(busy), .done(done), .h_out(h_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [255:0] hin;
    logic [511:0] blk;
    int           nstall;
    logic [255:0] dig;
    int           lat;
  } vec_t;

  typedef struct {
    string        name;
    logic [255:0] dig;
    int           start_edge;
    int           lat;
  } exp_t;

  vec_t        vt [4];
  exp_t        sb [$];
  logic [31:0] wq [64];
  int          stall [64];
  int          widx, stall_left, xfer, now, last_done;
  int          tests, fails;
  bit          got;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4 reference compression.
  function automatic logic [255:0] golden(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  x1, x2;
    logic [255:0] r;
    for (int j = 0; j < 16; j++) w[j] = blk[511 - 32*j -: 32];
    for (int j = 16; j < 64; j++)
      w[j] = (rotr(w[j-2], 17) ^ rotr(w[j-2], 19) ^ (w[j-2] >> 10)) + w[j-7]
           + (rotr(w[j-15], 7) ^ rotr(w[j-15], 18) ^ (w[j-15] >> 3)) + w[j-16];
    for (int j = 0; j < 8; j++) v[j] = hin[255 - 32*j -: 32];
    for (int j = 0; j < 64; j++) begin
      x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[j] + w[j];
      x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int m = 7; m > 0; m--) v[m] = v[m-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int j = 0; j < 8; j++) r[255 - 32*j -: 32] = hin[255 - 32*j -: 32] + v[j];
    return r;
  endfunction

  task automatic load_w(input logic [511:0] blk);
    for (int j = 0; j < 16; j++) wq[j] = blk[511 - 32*j -: 32];
    for (int j = 16; j < 64; j++)
      wq[j] = (rotr(wq[j-2], 17) ^ rotr(wq[j-2], 19) ^ (wq[j-2] >> 10)) + wq[j-7]
            + (rotr(wq[j-15], 7) ^ rotr(wq[j-15], 18) ^ (wq[j-15] >> 3)) + wq[j-16];
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive_w();
    if (w_ready && stall_left > 0) begin
      w_valid = 1'b0;
      w_in = $urandom;
      stall_left--;
    end else begin
      w_valid = 1'b1;
      w_in = (widx < 64) ? wq[widx] : $urandom;
      if (w_ready) begin
        xfer++;
        widx++;
        stall_left = (widx < 64) ? stall[widx] : 0;
      end
    end
  endtask

  task automatic monitor();
    exp_t x;
    if (done) begin
      got = 1'b1;
      last_done = now;
      if (sb.size() == 0) begin
        chk("unexpected_done", {255'b0, done}, 256'b0);
      end else begin
        x = sb.pop_front();
        chk_int({x.name, "_latency"}, now - x.start_edge + 1, x.lat);
        chk({x.name, "_digest"}, h_out, x.dig);
        chk_int({x.name, "_w_transfers"}, xfer, 64);
        chk({x.name, "_busy_at_done"}, {255'b0, busy}, 256'b0);
      end
    end
  endtask

  // Cycle n ends at edge n; outputs are sampled on the falling edge inside it.
  task automatic step();
    @(posedge clk);
    now++;
    @(negedge clk);
    start = 1'b0;
    monitor();
    drive_w();
  endtask

  task automatic launch(input string nm, input logic [255:0] hin, input logic [511:0] blk,
                        input int nstall, input logic [255:0] dig, input int lat);
    exp_t x;
    start = 1'b1;
    h_in  = hin;
    load_w(blk);
    for (int j = 0; j < 64; j++) stall[j] = 0;
    for (int k = 0; k < nstall; k++) stall[$urandom_range(0, 63)]++;
    widx = 0;
    xfer = 0;
    stall_left = stall[0];
    x.name = nm;
    x.dig = dig;
    x.start_edge = now + 1;
    x.lat = lat;
    sb.push_back(x);
    drive_w();
  endtask

  task automatic wait_done(input string nm, input int budget);
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) step();
    chk_int({nm, "_done_seen"}, int'(got), 1);
  endtask

  initial begin
    logic [511:0] rblk;
    logic [255:0] rh, blk1_out;
    int s, d1;
    tests = 0; fails = 0; now = 0; widx = 64; xfer = 0; stall_left = 0;
    rst_n = 1'b0; start = 1'b0; h_in = '0; w_in = '0; w_valid = 1'b0;
    for (int j = 0; j < 16; j++) rblk[511 - 32*j -: 32] = $urandom;
    for (int j = 0; j < 8; j++) rh[255 - 32*j -: 32] = $urandom;

    vt[0] = '{"abc",      IV,             BLK_ABC, 0,  ABC,                         201};
    vt[1] = '{"abc_bp40", IV,             BLK_ABC, 40, ABC,                         241};
    vt[2] = '{"wrap",     {256{1'b1}},    512'h0,  0,  golden({256{1'b1}}, 512'h0), 201};
    vt[3] = '{"rand_bp7", rh,             rblk,    7,  golden(rh, rblk),            208};

    repeat (2) @(negedge clk);
    chk("reset_busy",    {255'b0, busy},    256'b0);
    chk("reset_done",    {255'b0, done},    256'b0);
    chk("reset_w_ready", {255'b0, w_ready}, 256'b0);
    chk("reset_h_out",   h_out,             256'b0);
    rst_n = 1'b1;
    step();

    foreach (vt[n]) begin
      launch(vt[n].name, vt[n].hin, vt[n].blk, vt[n].nstall, vt[n].dig, vt[n].lat);
      step();
      chk({vt[n].name, "_busy_rise"}, {255'b0, busy}, 256'b1);
      wait_done(vt[n].name, 500);
      step();
      chk({vt[n].name, "_done_pulse"}, {255'b0, done}, 256'b0);
      chk({vt[n].name, "_h_out_hold"}, h_out, vt[n].dig);
      step();
    end

    // Two-block chaining, second start in the first block's DONE cycle
    launch("blk1", IV, BLK_M1, 0, golden(IV, BLK_M1), 201);
    wait_done("blk1", 500);
    d1 = last_done;
    blk1_out = h_out;
    launch("blk2", blk1_out, BLK_M2, 0, TWO, 201);
    wait_done("blk2", 500);
    chk_int("chain_done_spacing", last_done - d1, 201);
    step();

    // Starts during RT1/RA/RE/FIN must be ignored
    launch("ign_start", IV, BLK_ABC, 0, ABC, 201);
    s = now + 1;
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      step();
      if (now == s + 4 || now == s + 99 || now == s + 194) begin
        start = 1'b1;
        h_in  = ~IV;
      end
    end
    chk_int("ign_start_done_seen", int'(got), 1);
    step();

    // Reset in the middle of a run
    launch("rst_abort", IV, BLK_ABC, 0, ABC, 201);
    s = now + 1;
    while (now < s + 119) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",    {255'b0, busy},    256'b0);
    chk("midrst_done",    {255'b0, done},    256'b0);
    chk("midrst_w_ready", {255'b0, w_ready}, 256'b0);
    chk("midrst_h_out",   h_out,             256'b0);
    sb.delete();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    repeat (5) step();
    chk("post_rst_busy", {255'b0, busy}, 256'b0);
    launch("after_rst", IV, BLK_ABC, 0, ABC, 201);
    wait_done("after_rst", 500);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

SHA-256 compression controller that time-shares a single 32-bit five-operand modular adder (`add5`) across every addition of one 512-bit block compression. It holds the working variables a..h, the round counter and the K[t] constant ROM. It consumes the expanded message schedule W[0..63] as a valid/ready stream and produces the updated 256-bit chaining value. It sits between the message-schedule expander and the top-level hash wrapper.

## Interface
- No parameters. Data width is fixed at 32-bit words; the round count is fixed at 64.
- Reset is asynchronous and active-low. The block has one clock.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a compression; sampled only in IDLE or DONE.
- `h_in`  in  256  input chaining value {H0..H7}; H0 is in bits [255:224]; sampled on the accepted `start` edge.
- `w_in`  in  32  message schedule word W[t].
- `w_valid`  in  1  `w_in` is valid.
- `w_ready`  out  1  block accepts W[t] this cycle.
- `busy`  out  1  high from the accepted `start` until the DONE state.
- `done`  out  1  one-cycle pulse when `h_out` is updated.
- `h_out`  out  256  result {H0'..H7'}; holds its value until the next DONE.

## Operation
- The block contains one `add5` instance. Every sum is that adder's output: the 32-bit sum of five operands, truncated mod 2^32. Unused operand slots are driven with 0.
- The block also holds registers a..h, h_in copies H0..H7, t (6 bits), fin index i (3 bits), and T1.
- States and actions:
  - IDLE: `start`=1 → load a..h and H0..H7 from `h_in`, set t=0, go to RT1.
  - RT1: `w_ready`=1. When `w_valid`=1: T1 ← h + Σ1(e) + Ch(e,f,g) + K[t] + W, go to RA. When `w_valid`=0: stay.
  - RA: a_new ← T1 + Σ0(a) + Maj(a,b,c) + 0 + 0, held in a temporary register; go to RE.
  - RE: e_new ← d + T1 + 0 + 0 + 0. Shift: h←g, g←f, f←e, e←e_new, d←c, c←b, b←a, a←a_new. Then t←t+1. If t was 63, set i=0 and go to FIN; otherwise go to RT1.
  - FIN: H_i ← H_i + var_i + 0 + 0 + 0, where var_0..7 = a..h. Set i←i+1. After i=7, go to DONE.
  - DONE: `done`=1 and `h_out` is loaded from H0..H7 on entry. `start`=1 → behave as IDLE with `start`. Otherwise go to IDLE.
- Σ/Ch/Maj are the FIPS 180-4 definitions. K[0..63] is the FIPS 180-4 constant table.
- `start` in RT1/RA/RE/FIN is ignored and does not disturb the running compression.
- `w_ready` is 0 outside RT1. The producer may hold `w_valid` high; a word transfers only when `w_valid` and `w_ready` are both 1.

## Timing
- Reset values: `busy`=0, `done`=0, `w_ready`=0, `h_out`=0. State is IDLE, and t, i and all working registers are 0.
- Asserting `rst_n` low at any time, including mid-round or in FIN, aborts the compression immediately. No `done` is produced. A new `start` after release runs normally.
- With `w_valid` held at 1, each round takes 3 cycles. The `start` edge is cycle 0. W[0] is accepted at edge 1. W[t] is accepted at edge 1+3t. FIN occupies edges 193..200. `done` is high in cycle 201, and `h_out` is valid from the same edge.
- Each cycle in which `w_valid`=0 during RT1 adds exactly one cycle to the total latency.
- `busy` rises the cycle after the `start` edge and falls when DONE is entered.
- Back-to-back operation: `start` during the DONE cycle begins the next block with no IDLE bubble.
- All arithmetic wraps mod 2^32 with no carry out. This includes H_i + var_i in FIN.

## Test plan
- "abc" single block: `h_in` = standard IV (6a09e667 … 5be0cd19), W = expansion of the padded "abc" block, `w_valid` held at 1 → `done` at cycle 201, `h_out` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block chaining: the 448-bit "abcdbcdecdefdefg…nopq" message is fed as two blocks, with block 2's `start` asserted in block 1's DONE cycle and `h_in` = block 1's `h_out` → final `h_out` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. The second `done` arrives exactly 201 cycles after the first.
- Backpressure: the "abc" vector is fed with `w_valid` randomly low on 40 RT1 cycles → same digest. `done` arrives at cycle 241. No W word is duplicated or skipped (the bench checks the per-transfer count equals 64).
- Ignored start: `start` is pulsed at cycles 5, 100 and 195 with a different `h_in` during an "abc" run → digest unchanged and `done` at cycle 201.
- Reset mid-operation: `rst_n` is pulled low at cycle 120 → all outputs go to 0 immediately. After release, an "abc" run produces the correct digest with `done` 201 cycles after its `start`.
- Wrap-around: `h_in` = all ones and W all zero → `h_out` matches the golden model bit-exactly, with each FIN sum truncated mod 2^32.
